// File: rtl/cp0_except_pkg.sv
// cp0_except_pkg: shared constants for the MEM-stage CP0 block.
//   - CP0 register numbers, excepttype codes (including the refetch marker),
//     Cause.ExcCode values, Status/Cause bit positions, exc_flags bit indices.
//   - exccode_of(): maps an excepttype word to the ExcCode written into Cause.
package cp0_except_pkg;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam logic [31:0] ET_NONE    = 32'h0000_0000;
   localparam logic [31:0] ET_INT     = 32'h0000_0001;
   localparam logic [31:0] ET_ADEL    = 32'h0000_0004;
   localparam logic [31:0] ET_ADES    = 32'h0000_0005;
   localparam logic [31:0] ET_SYS     = 32'h0000_0008;
   localparam logic [31:0] ET_BP      = 32'h0000_0009;
   localparam logic [31:0] ET_RI      = 32'h0000_000a;
   localparam logic [31:0] ET_OV      = 32'h0000_000c;
   localparam logic [31:0] ET_TR      = 32'h0000_000d;
   localparam logic [31:0] ET_ERET    = 32'h0000_000e;
   localparam logic [31:0] ET_REFETCH = 32'hffff_ffff;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_TR   = 5'd13;

   localparam int ST_IE     = 0;
   localparam int ST_EXL    = 1;
   localparam int ST_IM_LO  = 8;
   localparam int ST_BEV    = 22;
   localparam int CA_EXC_LO = 2;
   localparam int CA_IP_LO  = 8;
   localparam int CA_TI     = 30;
   localparam int CA_BD     = 31;

   // exc_flags = {eret, ades, adel_data, trap, brk, syscall, ov, ri}
   localparam int FL_RI     = 0;
   localparam int FL_OV     = 1;
   localparam int FL_SYS    = 2;
   localparam int FL_BRK    = 3;
   localparam int FL_TRAP   = 4;
   localparam int FL_ADEL_D = 5;
   localparam int FL_ADES   = 6;
   localparam int FL_ERET   = 7;

   typedef enum logic [1:0] {
      BADV_NONE,
      BADV_PC,
      BADV_DATA
   } badv_src_e;

   function automatic logic [4:0] exccode_of(input logic [31:0] et);
      case (et)
         ET_ADEL: return EXC_ADEL;
         ET_ADES: return EXC_ADES;
         ET_SYS:  return EXC_SYS;
         ET_BP:   return EXC_BP;
         ET_RI:   return EXC_RI;
         ET_OV:   return EXC_OV;
         ET_TR:   return EXC_TR;
         default: return EXC_INT;
      endcase
   endfunction

endpackage

// File: rtl/cp0_except_if.sv
// cp0_except_if: MEM-stage <-> CP0 signal bundle.
//   master: pipeline side (drives instruction info, MTC0/MFC0, hw_int).
//   slave : CP0 side (returns rdata, excepttype, EPC, timer interrupt).
interface cp0_except_if #(
   parameter int HW_INT_W = 6
);
   logic                mem_valid;
   logic                mem_stall;
   logic [31:0]         mem_pc;
   logic                mem_in_ds;
   logic [7:0]          exc_flags;
   logic                adel_if;
   logic [31:0]         bad_addr;
   logic                cp0_we;
   logic [4:0]          cp0_waddr;
   logic [31:0]         cp0_wdata;
   logic [4:0]          cp0_raddr;
   logic [31:0]         cp0_rdata;
   logic [HW_INT_W-1:0] hw_int;
   logic [31:0]         excepttype_o;
   logic [31:0]         cp0_epc_o;
   logic                timer_int_o;

   modport master (
      output mem_valid, mem_stall, mem_pc, mem_in_ds, exc_flags, adel_if,
             bad_addr, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, hw_int,
      input  cp0_rdata, excepttype_o, cp0_epc_o, timer_int_o
   );

   modport slave (
      input  mem_valid, mem_stall, mem_pc, mem_in_ds, exc_flags, adel_if,
             bad_addr, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, hw_int,
      output cp0_rdata, excepttype_o, cp0_epc_o, timer_int_o
   );
endinterface

// File: rtl/cp0_except_timer.sv
// cp0_timer: Count/Compare pair with prescaler and sticky timer interrupt.
//   clk, resetn         : clock, async active-low reset
//   wr_count, wr_compare: committed MTC0 to Count / Compare
//   wdata               : MTC0 data
//   count, compare, ti  : register values and Cause.TI
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wr_count,
   input  logic        wr_compare,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [31:0]      count_q, count_d;
   logic [31:0]      compare_q, compare_d;
   logic             ti_q, ti_d;
   logic             tick;

   always_comb begin
      tick      = (div_q == DIV_LAST);
      div_d     = tick ? '0 : div_q + 1'b1;
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (wr_count)  count_d = wdata;
      else if (tick) count_d = count_q + 32'd1;
      if (wr_compare) compare_d = wdata;
      // TI is sticky; only a Compare write acknowledges it, and that write
      // beats a coincident match.
      if (wr_compare)                ti_d = 1'b0;
      else if (count_q == compare_q) ti_d = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q     <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         div_q     <= div_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign ti      = ti_q;

endmodule

// File: rtl/cp0_except.sv
// cp0_except: MEM-stage CP0 register file and exception arbiter.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : MEM instruction info, exception flags, MTC0/MFC0 ports,
//                 hw_int lines; returns excepttype_o, cp0_epc_o,
//                 timer_int_o and cp0_rdata.
module cp0_except
   import cp0_except_pkg::*;
#(
   parameter int COUNT_DIV = 2,
   parameter int HW_INT_W  = 6
) (
   input logic         clk,
   input logic         resetn,
   cp0_except_if.slave bus
);

   logic [31:0] epc_q, epc_d;
   logic [31:0] badv_q, badv_d;
   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [5:0]  ip_hw_q;

   logic [5:0]  hw_ext;
   logic [31:0] count, compare;
   logic        ti;
   logic [7:0]  ip;
   logic        int_pending;
   logic [31:0] exc_type;
   badv_src_e   badv_src;
   logic        exc_take, eret_take, mtc0_take;
   logic        wr_count, wr_compare;
   logic [31:0] status_rd, cause_rd;

   if (HW_INT_W >= 6) begin : g_hw_wide
      assign hw_ext = bus.hw_int[5:0];
   end else begin : g_hw_narrow
      assign hw_ext = {{(6 - HW_INT_W){1'b0}}, bus.hw_int};
   end

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk       (clk),
      .resetn    (resetn),
      .wr_count  (wr_count),
      .wr_compare(wr_compare),
      .wdata     (bus.cp0_wdata),
      .count     (count),
      .compare   (compare),
      .ti        (ti)
   );

   // IP[7] is shared between the top hardware line and the timer.
   assign ip          = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
   assign int_pending = ie_q & ~exl_q & (|(ip & im_q));

   always_comb begin
      exc_type = ET_NONE;
      badv_src = BADV_NONE;
      // Gated by resetn so the controller sees no exception while held in reset.
      if (resetn && bus.mem_valid && !bus.mem_stall) begin
         if (int_pending)                         exc_type = ET_INT;
         else if (bus.adel_if) begin              exc_type = ET_ADEL; badv_src = BADV_PC; end
         else if (bus.exc_flags[FL_RI])           exc_type = ET_RI;
         else if (bus.exc_flags[FL_OV])           exc_type = ET_OV;
         else if (bus.exc_flags[FL_TRAP])         exc_type = ET_TR;
         else if (bus.exc_flags[FL_SYS])          exc_type = ET_SYS;
         else if (bus.exc_flags[FL_BRK])          exc_type = ET_BP;
         else if (bus.exc_flags[FL_ADEL_D]) begin exc_type = ET_ADEL; badv_src = BADV_DATA; end
         else if (bus.exc_flags[FL_ADES]) begin   exc_type = ET_ADES; badv_src = BADV_DATA; end
         else if (bus.exc_flags[FL_ERET])         exc_type = ET_ERET;
         else if (bus.cp0_we && (bus.cp0_waddr == CP0_STATUS ||
                                 bus.cp0_waddr == CP0_CAUSE  ||
                                 bus.cp0_waddr == CP0_COMPARE))
            // These writes can change interrupt state, so the following
            // instructions must be refetched under the new state.
            exc_type = ET_REFETCH;
      end
   end

   assign exc_take   = (exc_type != ET_NONE) && (exc_type != ET_ERET) &&
                       (exc_type != ET_REFETCH);
   assign eret_take  = (exc_type == ET_ERET);
   assign mtc0_take  = resetn && bus.mem_valid && !bus.mem_stall && bus.cp0_we && !exc_take;
   assign wr_count   = mtc0_take && (bus.cp0_waddr == CP0_COUNT);
   assign wr_compare = mtc0_take && (bus.cp0_waddr == CP0_COMPARE);

   always_comb begin
      epc_d     = epc_q;
      badv_d    = badv_q;
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;
      bd_d      = bd_q;
      exccode_d = exccode_q;
      ip_sw_d   = ip_sw_q;
      if (exc_take) begin
         // Nested exceptions keep the original return point.
         if (!exl_q) begin
            epc_d = bus.mem_in_ds ? bus.mem_pc - 32'd4 : bus.mem_pc;
            bd_d  = bus.mem_in_ds;
         end
         exl_d     = 1'b1;
         exccode_d = exccode_of(exc_type);
         case (badv_src)
            BADV_PC:   badv_d = bus.mem_pc;
            BADV_DATA: badv_d = bus.bad_addr;
            default:   badv_d = badv_q;
         endcase
      end else begin
         if (mtc0_take) begin
            case (bus.cp0_waddr)
               CP0_STATUS: begin
                  im_d  = bus.cp0_wdata[15:8];
                  exl_d = bus.cp0_wdata[ST_EXL];
                  ie_d  = bus.cp0_wdata[ST_IE];
               end
               CP0_CAUSE: ip_sw_d = bus.cp0_wdata[9:8];
               CP0_EPC:   epc_d   = bus.cp0_wdata;
               default:   ;
            endcase
         end
         if (eret_take) exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         epc_q     <= '0;
         badv_q    <= '0;
         im_q      <= '0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         exccode_q <= '0;
         ip_sw_q   <= '0;
         ip_hw_q   <= '0;
      end else begin
         epc_q     <= epc_d;
         badv_q    <= badv_d;
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         exccode_q <= exccode_d;
         ip_sw_q   <= ip_sw_d;
         ip_hw_q   <= hw_ext;
      end
   end

   // BEV is hardwired: it resets to 1 and is not writable.
   always_comb begin
      status_rd                  = '0;
      status_rd[ST_BEV]          = 1'b1;
      status_rd[ST_IM_LO +: 8]   = im_q;
      status_rd[ST_EXL]          = exl_q;
      status_rd[ST_IE]           = ie_q;
      cause_rd                   = '0;
      cause_rd[CA_BD]            = bd_q;
      cause_rd[CA_TI]            = ti;
      cause_rd[CA_IP_LO +: 8]    = ip;
      cause_rd[CA_EXC_LO +: 5]   = exccode_q;
   end

   always_comb begin
      case (bus.cp0_raddr)
         CP0_BADVADDR: bus.cp0_rdata = badv_q;
         CP0_COUNT:    bus.cp0_rdata = count;
         CP0_COMPARE:  bus.cp0_rdata = compare;
         CP0_STATUS:   bus.cp0_rdata = status_rd;
         CP0_CAUSE:    bus.cp0_rdata = cause_rd;
         CP0_EPC:      bus.cp0_rdata = epc_q;
         default:      bus.cp0_rdata = 32'd0;
      endcase
   end

   assign bus.excepttype_o = exc_type;
   // An MTC0 EPC sitting beside an ERET must steer the return target now.
   assign bus.cp0_epc_o    = (bus.cp0_we && bus.cp0_waddr == CP0_EPC) ? bus.cp0_wdata : epc_q;
   assign bus.timer_int_o  = ti;

endmodule

// File: tb/tb_cp0_except.sv
module tb_cp0_except;
   import cp0_except_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] exp_q[$];

   cp0_except_if #(.HW_INT_W(6)) bus ();

   cp0_except #(.COUNT_DIV(2), .HW_INT_W(6)) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [31:0] e);
      exp_q.push_back(e);
   endtask

   task automatic sb_check(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s observed=0x%08h expected=<scoreboard empty>", tag, bus.excepttype_o);
      end else begin
         e = exp_q.pop_front();
         chk(tag, bus.excepttype_o, e);
      end
   endtask

   task automatic idle();
      bus.mem_valid = 1'b0;
      bus.mem_stall = 1'b0;
      bus.mem_pc    = '0;
      bus.mem_in_ds = 1'b0;
      bus.exc_flags = '0;
      bus.adel_if   = 1'b0;
      bus.bad_addr  = '0;
      bus.cp0_we    = 1'b0;
      bus.cp0_waddr = '0;
      bus.cp0_wdata = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      bus.cp0_raddr = a;
      #1;
      d = bus.cp0_rdata;
   endtask

   initial begin
      logic [31:0] v;
      bit found;
      resetn = 1'b0;
      idle();
      bus.hw_int    = '0;
      bus.cp0_raddr = '0;
      #0.5;
      rd(CP0_STATUS, v);  chk("rst_status", v, 32'h0040_0000);
      rd(CP0_CAUSE, v);   chk("rst_cause", v, 32'h0);
      rd(CP0_EPC, v);     chk("rst_epc", v, 32'h0);
      chk("rst_exctype", bus.excepttype_o, 32'h0);
      resetn = 1'b1;

      for (int i = 0; i < 20; i++) cyc();
      rd(CP0_COUNT, v);   chk("idle_count", v, 32'd10);
      rd(CP0_STATUS, v);  chk("idle_status", v, 32'h0040_0000);
      push(ET_NONE); sb_check("idle_exctype");
      bus.hw_int = 6'b000010;
      cyc();
      bus.hw_int = '0;
      rd(CP0_CAUSE, v);   chk("cause_ip_ti", v, 32'h4000_8800);

      cyc();
      bus.mem_valid = 1'b1; bus.mem_pc = 32'hbfc0_1000; bus.mem_in_ds = 1'b1;
      bus.exc_flags = 8'h04;
      push(ET_SYS); #1; sb_check("sys_exctype");
      cyc(); idle();
      rd(CP0_EPC, v);     chk("sys_epc", v, 32'hbfc0_0ffc);
      rd(CP0_CAUSE, v);   chk("sys_bd", {31'b0, v[31]}, 32'd1);
                          chk("sys_exccode", {27'b0, v[6:2]}, 32'd8);
      rd(CP0_STATUS, v);  chk("sys_status", v, 32'h0040_0002);

      cyc();
      bus.mem_valid = 1'b1; bus.mem_pc = 32'h300; bus.bad_addr = 32'h8000_0003;
      bus.exc_flags = 8'h42;
      push(ET_OV); #1; sb_check("ades_ov_exctype");
      cyc(); idle();
      rd(CP0_BADVADDR, v); chk("ades_ov_badv", v, 32'h0);
      rd(CP0_CAUSE, v);    chk("ades_ov_exccode", {27'b0, v[6:2]}, 32'd12);
      rd(CP0_EPC, v);      chk("nested_epc", v, 32'hbfc0_0ffc);

      cyc();
      bus.mem_valid = 1'b1; bus.mem_stall = 1'b1; bus.mem_pc = 32'h400;
      bus.exc_flags = 8'h04; bus.cp0_we = 1'b1; bus.cp0_waddr = CP0_EPC;
      bus.cp0_wdata = 32'h1234_5678;
      push(ET_NONE); #1; sb_check("stall_exctype");
      cyc(); idle();
      rd(CP0_EPC, v);     chk("stall_epc", v, 32'hbfc0_0ffc);
      rd(CP0_CAUSE, v);   chk("stall_exccode", {27'b0, v[6:2]}, 32'd12);

      cyc();
      bus.mem_valid = 1'b1; bus.cp0_we = 1'b1; bus.cp0_waddr = CP0_EPC;
      bus.cp0_wdata = 32'hbfc0_0040;
      push(ET_NONE); #1; sb_check("mtc0_epc_exctype");
      chk("epc_fwd", bus.cp0_epc_o, 32'hbfc0_0040);
      cyc(); idle();
      bus.mem_valid = 1'b1; bus.mem_pc = 32'h100; bus.exc_flags = 8'h80;
      bus.cp0_we = 1'b1; bus.cp0_waddr = CP0_EPC; bus.cp0_wdata = 32'h200;
      push(ET_ERET); #1; sb_check("eret_exctype");
      chk("eret_epc_fwd", bus.cp0_epc_o, 32'h200);
      rd(CP0_STATUS, v);  chk("eret_status_before", v, 32'h0040_0002);
      cyc(); idle();
      rd(CP0_STATUS, v);  chk("eret_status_after", v, 32'h0040_0000);
      rd(CP0_EPC, v);     chk("eret_epc_after", v, 32'h200);

      cyc();
      bus.mem_valid = 1'b1; bus.cp0_we = 1'b1; bus.cp0_waddr = CP0_COUNT; bus.cp0_wdata = 32'd0;
      push(ET_NONE); #1; sb_check("mtc0_count_exctype");
      cyc();
      bus.cp0_waddr = CP0_COMPARE; bus.cp0_wdata = 32'd5;
      push(ET_REFETCH); #1; sb_check("mtc0_compare_refetch");
      cyc();
      bus.cp0_waddr = CP0_STATUS; bus.cp0_wdata = 32'h0000_8001;
      push(ET_REFETCH); #1; sb_check("mtc0_status_refetch");
      cyc(); idle();
      bus.mem_valid = 1'b1; bus.mem_pc = 32'h500;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         rd(CP0_COUNT, v);
         if (v == 32'd5) found = 1'b1;
         else cyc();
      end
      chk("count_reach5", v, 32'd5);
      chk("ti_before_match", {31'b0, bus.timer_int_o}, 32'd0);
      push(ET_NONE); sb_check("int_not_yet");
      cyc();
      push(ET_INT); #1; sb_check("int_exctype");
      chk("ti_rise", {31'b0, bus.timer_int_o}, 32'd1);
      cyc(); idle();
      rd(CP0_EPC, v);     chk("int_epc", v, 32'h500);
      rd(CP0_CAUSE, v);   chk("int_exccode", {27'b0, v[6:2]}, 32'd0);
      rd(CP0_STATUS, v);  chk("int_status", v, 32'h0040_8003);

      cyc();
      bus.mem_valid = 1'b1; bus.cp0_we = 1'b1; bus.cp0_waddr = CP0_COMPARE;
      bus.cp0_wdata = 32'd100;
      push(ET_REFETCH); #1; sb_check("compare_clr_refetch");
      cyc(); idle();
      #1; chk("ti_clear", {31'b0, bus.timer_int_o}, 32'd0);

      cyc();
      bus.mem_valid = 1'b1; bus.mem_pc = 32'h600; bus.adel_if = 1'b1;
      push(ET_ADEL); #1; sb_check("adel_if_exctype");
      cyc(); idle();
      rd(CP0_BADVADDR, v); chk("adel_if_badv", v, 32'h600);
      rd(CP0_EPC, v);      chk("adel_if_epc_kept", v, 32'h500);
      rd(5'd3, v);         chk("mfc0_unimpl", v, 32'h0);

      cyc();
      bus.mem_valid = 1'b1; bus.mem_pc = 32'h700; bus.exc_flags = 8'h04;
      push(ET_SYS); #1; sb_check("pre_reset_exctype");
      #0.5; resetn = 1'b0;
      #0.5; push(ET_NONE); sb_check("mid_reset_exctype");
      rd(CP0_STATUS, v);   chk("mid_reset_status", v, 32'h0040_0000);
      rd(CP0_EPC, v);      chk("mid_reset_epc", v, 32'h0);
      rd(CP0_BADVADDR, v); chk("mid_reset_badv", v, 32'h0);
      rd(CP0_CAUSE, v);    chk("mid_reset_cause", v, 32'h0);
      rd(CP0_COUNT, v);    chk("mid_reset_count", v, 32'h0);
      rd(CP0_COMPARE, v);  chk("mid_reset_compare", v, 32'h0);
      chk("mid_reset_ti", {31'b0, bus.timer_int_o}, 32'd0);
      idle();
      @(negedge clk);
      resetn = 1'b1;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cp0_except.md
Name: cp0_except

Overview:
- MEM-stage CP0 register file and exception arbiter.
- Collects per-instruction exception flags and pending interrupts, then produces the prioritised excepttype word and the EPC value consumed by the pipeline controller.
- Commits architectural CP0 state (Status/Cause/EPC/BadVAddr/Count/Compare) on exception entry, ERET and MTC0.
- Also provides MFC0 read data.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (power of two, 1..4).
- HW_INT_W, 6, number of hardware interrupt lines (Cause.IP[7:2]).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM holds a real (non-bubble) instruction
- mem_stall  in  1  MEM stage stalled this cycle; no commit, no exception raised
- mem_pc  in  32  PC of MEM instruction
- mem_in_ds  in  1  instruction sits in a branch delay slot
- exc_flags  in  8  {eret, ades, adel_data, trap, brk, syscall, ov, ri}
- adel_if  in  1  fetch address error carried from IF
- bad_addr  in  32  faulting data address for adel_data/ades
- cp0_we  in  1  MTC0 commit
- cp0_waddr  in  5  MTC0 register number
- cp0_wdata  in  32  MTC0 data
- cp0_raddr  in  5  MFC0 register number
- cp0_rdata  out  32  MFC0 data (combinational from registers)
- hw_int  in  HW_INT_W  external interrupt lines, level-sensitive
- excepttype_o  out  32  exception code to pipeline controller, 0 = none
- cp0_epc_o  out  32  EPC with same-cycle MTC0-to-EPC forwarding
- timer_int_o  out  1  Cause.TI

Behaviour:
- Reset (resetn=0, async):
  - Status = 0x0040_0000 (BEV=1); Cause, EPC, BadVAddr, Count, Compare = 0.
  - Divider counter = 0; excepttype_o = 0.
- Count/Compare:
  - Divider wraps at COUNT_DIV; Count += 1 on wrap, wraps 0xFFFF_FFFF -> 0.
  - Count == Compare (both nonzero-written or not) sets TI on the next edge.
  - MTC0 Compare clears TI the same edge.
  - MTC0 Count overrides the increment that edge.
- Cause.IP[7:2] sampled from hw_int every cycle. IP[7] = hw_int[5] | TI.
- Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- excepttype_o, combinational; 0 when ~mem_valid or mem_stall. Priority:
  - int: 0x1
  - adel_if: 0x4
  - ri: 0xa
  - ov: 0xc
  - trap: 0xd
  - syscall: 0x8
  - brk: 0x9
  - adel_data: 0x4
  - ades: 0x5
  - eret: 0xe
  - otherwise 0.
- MTC0 to Status/Cause/Compare with no exception outputs 0xffffffff (refetch). The controller redirects to pc+4.
- Commit at the edge when excepttype ∉ {0, 0xe, 0xffffffff}:
  - If EXL=0: EPC = mem_in_ds ? mem_pc-4 : mem_pc, and Cause.BD = mem_in_ds.
  - EXL is set to 1. Cause.ExcCode = code: int->0, adel->4, ades->5, sys->8, bp->9, ri->10, ov->12, tr->13.
  - BadVAddr = mem_pc for adel_if, bad_addr for adel_data/ades.
  - A concurrent MTC0 from the faulting instruction is discarded.
- ERET commit: EXL cleared. cp0_epc_o = EPC (or cp0_wdata if cp0_we & waddr==14 that cycle).
- MTC0 writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - EPC, Compare, Count: full width.
  - BadVAddr is read-only. Writes to unimplemented registers are ignored.
- MFC0 of unimplemented register returns 0.
- Simultaneous interrupt and synchronous exception: interrupt wins, and EPC = pc of the interrupted instruction.

Decomposition:
- Shared package/defines hold:
  - CP0 register numbers (8, 9, 11, 12, 13, 14).
  - excepttype code constants, including 0xffffffff refetch.
  - ExcCode values.
  - Status/Cause bit positions.
- One sub-module is natural: cp0_timer (divider, Count, Compare, TI).

Test Plan:
- Reset then idle 20 cycles with COUNT_DIV=2 -> Count=10, Status=0x0040_0000, excepttype_o=0.
- Syscall at pc 0xbfc0_1000, in_ds=1 -> excepttype_o=0x8; next cycle EPC=0xbfc0_0ffc, Cause.BD=1, ExcCode=8, EXL=1.
- ades with bad_addr 0x8000_0003 plus ov in same instruction -> excepttype_o=0xc (ov wins), BadVAddr unchanged.
- Compare=5, Status=0x0000_8001, valid instruction -> TI rises at Count=5, excepttype_o=0x1. MTC0 Compare then clears TI.
- ERET at pc 0x100 with EPC=0xbfc0_0040 and same-cycle MTC0 EPC=0x200 -> excepttype_o=0xe, cp0_epc_o=0x200, EXL cleared next edge.
- mem_stall=1 with syscall flag -> excepttype_o=0 and no state change. Async resetn mid-exception returns all registers to reset values immediately.
